fft_output_serializer: RTL and testbench

FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_output_serializer.sv | 92 +++++++++
 tb/tb_fft_output_serializer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, frame-serializer state encoding and the 5-bit bit-reversal helper.
package fft_pkg;

    localparam int unsigned FFT_POINTS = 32;
    localparam int unsigned FFT_LOG2   = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    // Maps {b4..b0} to {b0..b4}; converts a bit-reversed lane index to natural order.
    function automatic logic [FFT_LOG2-1:0] bitrev5(input logic [FFT_LOG2-1:0] v);
        logic [FFT_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < int'(FFT_LOG2); i++) begin
            r[i] = v[int'(FFT_LOG2) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_serializer.sv
// Captures a 32-lane parallel FFT frame and streams it out one bin per beat with
// valid/ready handshake, optionally undoing the bit-reversed lane order.
module fft_output_serializer
    import fft_pkg::*;
#(
    parameter int unsigned p_dataBits   = 20,
    parameter int unsigned p_bitReverse = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [FFT_POINTS*p_dataBits-1:0] i_frame,
    input  logic                             i_frame_valid,
    output logic                             o_frame_ready,
    output logic [p_dataBits-1:0]            o_data,
    output logic [FFT_LOG2-1:0]              o_index,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_last
);

    ser_state_t             r_state;
    ser_state_t             w_state_nxt;
    logic [FFT_LOG2-1:0]    r_cnt;
    logic [p_dataBits-1:0]  r_buf [FFT_POINTS];

    logic                   w_last_idx;
    logic                   w_beat;
    logic                   w_accept;
    logic [FFT_LOG2-1:0]    w_lane;

    assign w_last_idx    = (r_cnt == FFT_LOG2'(FFT_POINTS - 1));
    assign o_valid       = (r_state == STREAM);
    assign w_beat        = o_valid && i_ready;
    // Ready on the final beat lets the next frame follow with no bubble.
    assign o_frame_ready = (r_state == IDLE) || (w_beat && w_last_idx);
    assign w_accept      = i_frame_valid && o_frame_ready;

    assign w_lane  = (p_bitReverse != 0) ? bitrev5(r_cnt) : r_cnt;
    assign o_index = r_cnt;
    assign o_data  = r_buf[w_lane];
    assign o_last  = o_valid && w_last_idx;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_beat && w_last_idx) begin
                    w_state_nxt = w_accept ? STREAM : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bin counter: restarts on every accepted frame, advances per beat.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + FFT_LOG2'(1);
        end
    end

    // Frame buffer only loads on acceptance, so it is frozen mid-frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int n = 0; n < int'(FFT_POINTS); n++) begin
                r_buf[n] <= '0;
            end
        end else if (w_accept) begin
            for (int n = 0; n < int'(FFT_POINTS); n++) begin
                r_buf[n] <= i_frame[n*p_dataBits +: p_dataBits];
            end
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer: reset, natural-order streaming,
// backpressure, back-to-back frames, ignored frame and mid-frame reset.
module tb_fft_output_serializer;

    localparam int unsigned W = 20;

    logic            CLK;
    logic            RST;
    logic [32*W-1:0] i_frame;
    logic            i_frame_valid;
    logic            o_frame_ready;
    logic [W-1:0]    o_data;
    logic [4:0]      o_index;
    logic            o_valid;
    logic            i_ready;
    logic            o_last;

    int n_cmp;
    int n_err;

    fft_output_serializer #(
        .p_dataBits   (W),
        .p_bitReverse (1)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_frame       (i_frame),
        .i_frame_valid (i_frame_valid),
        .o_frame_ready (o_frame_ready),
        .o_data        (o_data),
        .o_index       (o_index),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // sel 0: lane n = n + 100; sel 1: lane n = 0xFFFFF - n
    function automatic logic [32*W-1:0] mk_frame(input int sel);
        logic [32*W-1:0] f;
        for (int n = 0; n < 32; n++) begin
            f[n*W +: W] = (sel == 0) ? W'(n + 100) : W'(32'hFFFFF - n);
        end
        return f;
    endfunction

    function automatic logic [W-1:0] exp_word(input int sel, input int idx);
        logic [4:0] k;
        logic [4:0] lane;
        k    = 5'(idx);
        lane = {k[0], k[1], k[2], k[3], k[4]};
        return (sel == 0) ? W'(32'(lane) + 100) : W'(32'hFFFFF - 32'(lane));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_beat(input int sel, input int k);
        chk($sformatf("valid[%0d]", k), 32'(o_valid), 32'd1);
        chk($sformatf("index[%0d]", k), 32'(o_index), 32'(k));
        chk($sformatf("data[%0d]", k),  32'(o_data),  32'(exp_word(sel, k)));
        chk($sformatf("last[%0d]", k),  32'(o_last),  (k == 31) ? 32'd1 : 32'd0);
    endtask

    task automatic stream_check(input int sel, input int from, input int to);
        i_ready = 1'b1;
        for (int k = from; k <= to; k++) begin
            check_beat(sel, k);
            tick();
        end
    endtask

    task automatic accept_frame(input int sel);
        i_frame       = mk_frame(sel);
        i_frame_valid = 1'b1;
        chk("frame_ready_idle", 32'(o_frame_ready), 32'd1);
        tick();
        i_frame_valid = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        RST           = 1'b0;
        i_frame       = '0;
        i_frame_valid = 1'b0;
        i_ready       = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_valid",  32'(o_valid),       32'd0);
        chk("rst_index",  32'(o_index),       32'd0);
        chk("rst_data",   32'(o_data),        32'd0);
        chk("rst_last",   32'(o_last),        32'd0);
        chk("rst_fready", 32'(o_frame_ready), 32'd1);
        RST = 1'b1;
        tick();

        // Natural order, full throughput
        i_ready = 1'b1;
        accept_frame(0);
        chk("nat_fready_busy", 32'(o_frame_ready), 32'd0);
        stream_check(0, 0, 31);
        chk("nat_done_valid",  32'(o_valid),       32'd0);
        chk("nat_done_fready", 32'(o_frame_ready), 32'd1);

        // Backpressure at index 5
        accept_frame(0);
        stream_check(0, 0, 4);
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_valid_c%0d", c), 32'(o_valid), 32'd1);
            chk($sformatf("bp_index_c%0d", c), 32'(o_index), 32'd5);
            chk($sformatf("bp_data_c%0d", c),  32'(o_data),  32'(exp_word(0, 5)));
            tick();
        end
        stream_check(0, 5, 31);
        chk("bp_done_valid", 32'(o_valid), 32'd0);

        // Back-to-back: second frame held valid throughout the first
        accept_frame(0);
        i_frame       = mk_frame(1);
        i_frame_valid = 1'b1;
        i_ready       = 1'b1;
        for (int k = 0; k <= 31; k++) begin
            check_beat(0, k);
            chk($sformatf("b2b_fready[%0d]", k), 32'(o_frame_ready), (k == 31) ? 32'd1 : 32'd0);
            tick();
        end
        i_frame_valid = 1'b0;
        stream_check(1, 0, 31);
        chk("b2b_done_valid", 32'(o_valid), 32'd0);

        // Ignored frame pulse at index 10
        accept_frame(0);
        stream_check(0, 0, 9);
        i_frame       = mk_frame(1);
        i_frame_valid = 1'b1;
        chk("ign_fready", 32'(o_frame_ready), 32'd0);
        check_beat(0, 10);
        tick();
        i_frame_valid = 1'b0;
        stream_check(0, 11, 31);

        // Mid-frame reset at index 12, frame offered during reset
        accept_frame(0);
        stream_check(0, 0, 11);
        chk("mr_index_pre", 32'(o_index), 32'd12);
        RST           = 1'b0;
        i_frame       = mk_frame(1);
        i_frame_valid = 1'b1;
        tick();
        chk("mr_valid", 32'(o_valid), 32'd0);
        chk("mr_index", 32'(o_index), 32'd0);
        RST           = 1'b1;
        i_frame_valid = 1'b0;
        tick();
        chk("mr_not_captured", 32'(o_valid), 32'd0);
        accept_frame(1);
        stream_check(1, 0, 31);
        chk("mr_done_valid", 32'(o_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
